// File: rtl/nibble_serial_addsub.sv
// Serial adder/subtractor: WIDTH-bit operands through one 4-bit carry chain, LS nibble first.
// Optional NIBBLE_ADDSUB_SAT_EN: saturate result on signed overflow.
module nibble_serial_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_chk
    $error("nibble_serial_addsub: WIDTH must be a multiple of 4 and >= 8");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             cout_q;
  logic             ovf_q;

  logic [3:0]       sum_d;
  logic [4:0]       c_d;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] final_d;

  // b_q already holds B inverted for subtract; carry_q seeds the chain
  always_comb begin
    c_d    = '0;
    sum_d  = '0;
    c_d[0] = carry_q;
    for (int i = 0; i < 4; i++) begin
      sum_d[i]  = a_q[i] ^ b_q[i] ^ c_d[i];
      c_d[i+1]  = (a_q[i] & b_q[i]) | (c_d[i] & (a_q[i] ^ b_q[i]));
    end
  end

  assign acc_d = {sum_d, acc_q[WIDTH-1:4]};

`ifdef NIBBLE_ADDSUB_SAT_EN
  // On overflow the true sign follows A's MSB for both add and subtract
  always_comb begin
    final_d = acc_d;
    if (c_d[3] ^ c_d[4]) begin
      final_d = a_q[3] ? {1'b1, {(WIDTH-1){1'b0}}}
                       : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign final_d = acc_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= op_a;
            b_q        <= op_b ^ {WIDTH{sub}};
            carry_q    <= sub;
            cnt_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          acc_q   <= acc_d;
          carry_q <= c_d[4];
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= final_d;
            cout_q      <= c_d[4];
            ovf_q       <= c_d[3] ^ c_d[4];
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
Multi-word adder/subtractor that sequences WIDTH-bit operands through a 4-bit ripple-carry datapath, one nibble per clock, least-significant nibble first.
The carry is registered between nibbles.
Sits upstream of result consumers and is fed by the operand source over a valid/ready handshake.
Trades latency for area: one 4-bit full-adder chain is reused for all nibbles.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 8 (elaboration error otherwise)

Ports:
clk  input  1  single clock, rising-edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand source has a request
in_ready  output  1  block can accept a request
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B
sub  input  1  0 = A+B, 1 = A-B
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
result  output  WIDTH  sum/difference
cout  output  1  final carry; for subtract, 1 = no borrow (A >= B unsigned)
overflow  output  1  signed two's-complement overflow
busy  output  1  high in RUN or DONE

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
- On rst, regardless of state (including mid-RUN): state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, cout=0, overflow=0. Any in-flight operation is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready at edge k: capture op_a, op_b^{WIDTH{sub}}, sub; set carry register=sub, nibble counter=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each edge computes one nibble with a 4-bit full-adder chain: A nibble + inverted-or-plain B nibble + carry register.
  - The 4-bit sum is written into the result register at the nibble position; the carry register takes the nibble carry-out; the counter increments.
  - After the edge processing nibble WIDTH/4-1, i.e. edge k+WIDTH/4, go to DONE.
- Latency: out_valid rises WIDTH/4 cycles after the accept edge (4 cycles for WIDTH=16).
- Carry handling: B inversion for subtract applies to every nibble; carry-in equals sub only for nibble 0, and later nibbles use the registered carry. The datapath does not reuse a slice that ties inversion to carry-in.
- DONE:
  - out_valid=1; result, cout and overflow are held stable while out_ready=0.
  - cout = final carry register.
  - overflow = carry-in XOR carry-out of the MSB bit position of the last nibble. Capture the carry into bit WIDTH-1 during the final nibble.
  - On out_valid&&out_ready, go to IDLE; in_ready returns the next cycle (no same-cycle bypass).
- in_valid while not in IDLE is ignored and must be held by the source.
- Operands are sampled only at the accept edge; later changes on op_a/op_b/sub have no effect.
- Outputs in IDLE hold the last result, cout and overflow until the next accept, then update only in DONE. The partial result register is internal; result presents the final value only.
- Arithmetic is modulo 2^WIDTH; no extension bits.

Optional Feature:
Macro NIBBLE_ADDSUB_SAT_EN.
- Defined: when overflow=1 in DONE, result is saturated:
  - 0 {WIDTH-1{1}} (most positive) if the true signed result was positive, i.e. A MSB=0 for subtract or both operand MSBs=0 for add.
  - 1 {WIDTH-1{0}} (most negative) otherwise.
  - overflow and cout still report the raw values.
- Not defined: result is always the wrapped modulo value; no saturation logic is present.

Test Plan:
1. WIDTH=16, accept op_a=0x1234, op_b=0x0FCD, sub=0 -> out_valid 4 cycles after accept, result=0x2201, cout=0, overflow=0.
2. op_a=0x0005, op_b=0x0007, sub=1 -> result=0xFFFE, cout=0 (borrow), overflow=0; then 0x0007-0x0005 -> 0x0002, cout=1.
3. op_a=0x7FFF, op_b=0x0001, sub=0 -> result=0x8000, overflow=1, cout=0; with NIBBLE_ADDSUB_SAT_EN -> result=0x7FFF, overflow=1. Also 0x8000-0x0001 -> 0x7FFF, overflow=1; SAT -> 0x8000.
4. op_a=0xFFFF, op_b=0x0001, sub=0 -> result=0x0000, cout=1, overflow=0 (carry ripples across all four nibbles).
5. Backpressure: out_ready=0 for 3 cycles in DONE -> out_valid, result and flags stable, in_ready=0, a new in_valid is ignored; out_ready=1 -> IDLE, in_ready=1 next cycle, then back-to-back accept works.
6. Assert rst during RUN after 2 nibbles -> next cycle state IDLE, out_valid=0, result=0, in_ready=1; a subsequent 0x0001+0x0001 -> 0x0002.
